// File: rtl/fb_display_exec.sv
// Reads one pixel from the framebuffer and plots it via the VGA adapter.
// Bad opcodes or off-screen coordinates complete with an error status instead.
module fb_display_exec #(
  parameter int unsigned X_COORD_WIDTH     = 8,
  parameter int unsigned Y_COORD_WIDTH     = 7,
  parameter int unsigned SCREEN_WIDTH      = 160,
  parameter int unsigned SCREEN_HEIGHT     = 120,
  parameter int unsigned OPCODE_WIDTH      = 4,
  parameter logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = OPCODE_WIDTH'(2),
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned RESULT_WIDTH      = 16,
  parameter int unsigned COLOUR_WIDTH      = 3,
  parameter int unsigned ADDR_WIDTH        = 15
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic                         fb_rd,
  output logic [ADDR_WIDTH-1:0]        fb_addr,
  input  logic [COLOUR_WIDTH-1:0]      fb_rdata,
  output logic                         vga_plot,
  output logic [X_COORD_WIDTH-1:0]     vga_x,
  output logic [Y_COORD_WIDTH-1:0]     vga_y,
  output logic [COLOUR_WIDTH-1:0]      vga_colour
);

  localparam int unsigned X_LSB   = OPCODE_WIDTH;
  localparam int unsigned Y_LSB   = X_LSB + X_COORD_WIDTH;
  localparam int unsigned PAD_LSB = Y_LSB + Y_COORD_WIDTH;

  typedef enum logic [2:0] {IDLE, READ, WAIT_RD, PLOT, ERR} state_t;

  state_t                    state;
  logic                      start_q;
  logic                      req;
  logic [OPCODE_WIDTH-1:0]   op_q;
  logic [X_COORD_WIDTH-1:0]  x_q;
  logic [Y_COORD_WIDTH-1:0]  y_q;

  logic                      op_ok;
  logic                      coord_ok;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [RESULT_WIDTH-1:0]   err_result;
  logic                      unused_pad;

  assign unused_pad = ^instruction[INSTRUCTION_WIDTH-1:PAD_LSB];

  // Decode of the latched request; only consumed while the fields are stable
  assign op_ok      = (op_q == OPCODE_DISPLAY);
  assign coord_ok   = (32'(x_q) < SCREEN_WIDTH) && (32'(y_q) < SCREEN_HEIGHT);
  assign addr       = ADDR_WIDTH'(y_q) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(x_q);
  assign err_result = {1'b1, {(RESULT_WIDTH-1){1'b0}}}
                    | (op_ok ? RESULT_WIDTH'(1) : RESULT_WIDTH'(2));

  // Request edge is registered first (req), then acted on from IDLE the next cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      req        <= 1'b0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      finished   <= 1'b1;
      result     <= '0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (req) begin
            req      <= 1'b0;
            finished <= 1'b0;
            result   <= '0;
            if (op_ok && coord_ok) begin
              state   <= READ;
              fb_rd   <= 1'b1;
              fb_addr <= addr;
            end else begin
              state <= ERR;
            end
          end else if (start && !start_q) begin
            req  <= 1'b1;
            op_q <= instruction[OPCODE_WIDTH-1:0];
            x_q  <= instruction[X_LSB +: X_COORD_WIDTH];
            y_q  <= instruction[Y_LSB +: Y_COORD_WIDTH];
          end
        end
        READ: begin
          fb_rd <= 1'b0;
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          vga_plot   <= 1'b1;
          vga_x      <= x_q;
          vga_y      <= y_q;
          vga_colour <= fb_rdata;
          state      <= PLOT;
        end
        PLOT: begin
          vga_plot <= 1'b0;
          finished <= 1'b1;
          result   <= RESULT_WIDTH'(vga_colour);
          state    <= IDLE;
        end
        ERR: begin
          finished <= 1'b1;
          result   <= err_result;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_display_exec.sv
// Randomized bench for fb_display_exec with a transaction-level timing model
// and a few directed pixel/error/reset scenarios.
module tb_fb_display_exec;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic        finished;
  logic [15:0] result;
  logic        fb_rd;
  logic [14:0] fb_addr;
  logic [2:0]  fb_rdata = '0;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  fb_display_exec dut (
    .clock(clock), .resetn(resetn), .start(start), .instruction(instruction),
    .finished(finished), .result(result), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_rdata(fb_rdata), .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Framebuffer: data valid only in the cycle after a read strobe, junk otherwise
  logic [2:0] mem [0:32767];
  always @(posedge clock) begin
    if (fb_rd) fb_rdata <= mem[fb_addr];
    else       fb_rdata <= 3'($urandom);
  end

  // Behavioural model: a request sampled at edge S drives outputs at S+1..S+4
  int          cyc = 0;
  int          last_s = -1000;
  int          next_free = 0;
  int          d;
  logic        prev_start = 1'b0;
  logic        m_ok = 1'b0;
  logic [3:0]  m_op;
  int          m_x, m_y;
  int          m_addr;
  logic [2:0]  m_col;
  logic        exp_fin = 1'b1;
  logic [15:0] exp_res = '0;
  logic        exp_fbrd = 1'b0;
  logic [14:0] exp_addr = '0;
  logic        exp_plot = 1'b0;
  logic [7:0]  exp_x = '0;
  logic [6:0]  exp_y = '0;
  logic [2:0]  exp_col = '0;

  always @(negedge resetn) begin
    last_s = -1000; next_free = 0; prev_start = 1'b0;
    exp_fin = 1'b1; exp_res = '0; exp_fbrd = 1'b0; exp_addr = '0;
    exp_plot = 1'b0; exp_x = '0; exp_y = '0; exp_col = '0;
  end

  always @(posedge clock) begin
    if (resetn) begin
      cyc++;
      d = cyc - last_s;
      exp_fbrd = m_ok && (d == 1);
      exp_plot = m_ok && (d == 3);
      if (d == 1) begin
        exp_fin = 1'b0;
        exp_res = '0;
        if (m_ok) exp_addr = 15'(m_addr);
      end
      if (m_ok && d == 3) begin
        exp_x = 8'(m_x); exp_y = 7'(m_y); exp_col = m_col;
      end
      if (m_ok && d == 4) begin
        exp_fin = 1'b1; exp_res = 16'(m_col);
      end
      if (!m_ok && d == 2) begin
        exp_fin = 1'b1;
        exp_res = (m_op != 4'd2) ? 16'h8002 : 16'h8001;
      end
      if (start && !prev_start && cyc >= next_free) begin
        m_op   = instruction[3:0];
        m_x    = int'(instruction[11:4]);
        m_y    = int'(instruction[18:12]);
        m_ok   = (m_op == 4'd2) && (m_x < 160) && (m_y < 120);
        m_addr = m_y * 160 + m_x;
        m_col  = m_ok ? mem[m_addr] : 3'd0;
        last_s = cyc;
        next_free = cyc + (m_ok ? 5 : 3);
      end
      prev_start = start;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    check("finished", finished, exp_fin);
    check("result", result, exp_res);
    check("fb_rd", fb_rd, exp_fbrd);
    check("fb_addr", fb_addr, exp_addr);
    check("vga_plot", vga_plot, exp_plot);
    check("vga_x", vga_x, exp_x);
    check("vga_y", vga_y, exp_y);
    check("vga_colour", vga_colour, exp_col);
  end

  // Pulse bookkeeping for the directed literal checks
  int          fbrd_cnt = 0, plot_cnt = 0;
  logic [14:0] last_addr = '0;
  logic [7:0]  last_px = '0;
  logic [6:0]  last_py = '0;
  logic [2:0]  last_pc = '0;
  logic        prev_fin = 1'b1;
  int          fin_cyc = 0, req_cyc = 0;
  always @(negedge clock) begin
    if (fb_rd) begin fbrd_cnt++; last_addr = fb_addr; end
    if (vga_plot) begin plot_cnt++; last_px = vga_x; last_py = vga_y; last_pc = vga_colour; end
    if (finished && !prev_fin) fin_cyc = cyc;
    prev_fin = finished;
  end

  task automatic run_req(input int op, input int x, input int y, input int hold, input int gap);
    @(negedge clock);
    instruction = {13'($urandom), 7'(y), 8'(x), 4'(op)};
    start = 1'b1;
    req_cyc = cyc + 1;
    repeat (hold) @(negedge clock);
    start = 1'b0;
    instruction = $urandom;
    repeat (gap) @(negedge clock);
    #1;
  endtask

  task automatic clear_counts();
    fbrd_cnt = 0; plot_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
    mem[485]   = 3'b101;
    mem[19199] = 3'b011;

    repeat (3) @(negedge clock);
    #1;
    check("rst_finished", finished, 1);
    check("rst_result", result, 0);
    check("rst_fb_rd", fb_rd, 0);
    check("rst_plot", vga_plot, 0);
    @(negedge clock);
    #2 resetn = 1'b1;

    // Basic display
    clear_counts();
    run_req(2, 5, 3, 2, 8);
    check("d1_fbrd_cnt", fbrd_cnt, 1);
    check("d1_plot_cnt", plot_cnt, 1);
    check("d1_addr", last_addr, 485);
    check("d1_px", last_px, 5);
    check("d1_py", last_py, 3);
    check("d1_col", last_pc, 5);
    check("d1_result", result, 16'h0005);
    check("d1_latency", fin_cyc - req_cyc, 4);

    // Bottom-right corner
    clear_counts();
    run_req(2, 159, 119, 2, 8);
    check("d2_addr", last_addr, 19199);
    check("d2_px", last_px, 159);
    check("d2_py", last_py, 119);
    check("d2_result", result, 16'h0003);

    // Off-screen x
    clear_counts();
    run_req(2, 160, 0, 2, 6);
    check("d3_fbrd_cnt", fbrd_cnt, 0);
    check("d3_plot_cnt", plot_cnt, 0);
    check("d3_result", result, 16'h8001);
    check("d3_latency", fin_cyc - req_cyc, 2);

    // Bad opcode, alone and combined with a bad coordinate
    run_req(7, 5, 3, 2, 6);
    check("d4_result", result, 16'h8002);
    run_req(7, 200, 0, 2, 6);
    check("d5_result", result, 16'h8002);

    // Long start hold must not retrigger
    clear_counts();
    run_req(2, 10, 20, 6, 8);
    check("d6_fbrd_cnt", fbrd_cnt, 1);
    check("d6_plot_cnt", plot_cnt, 1);

    // Reset while waiting on the read, then start already high at release
    clear_counts();
    @(negedge clock);
    instruction = {13'd0, 7'd7, 8'd7, 4'd2};
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("ar_finished", finished, 1);
    check("ar_plot", vga_plot, 0);
    check("ar_fb_rd", fb_rd, 0);
    @(negedge clock);
    @(negedge clock);
    #2;
    instruction = {13'd0, 7'd0, 8'd0, 4'd2};
    resetn = 1'b1;
    start = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check("ar_plot_cnt", plot_cnt, 1);
    check("ar_fbrd_cnt", fbrd_cnt, 2);
    check("ar_addr", last_addr, 0);
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    check("ar_result", result, 16'(mem[0]));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      int op;
      op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 2;
      run_req(op, int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
              int'($urandom_range(1, 6)), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clock);
        #2 resetn = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b1;
      end
    end
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
